// File: rtl/bp_be_pkg.sv
// Backend integer-pipe shared types: configuration selector, register-file constants
// and the per-packet hazard descriptor used by the issue queue and scoreboard.
`define BP_BE_ISSUE_HAZARD_WIDTH $bits(bp_be_pkg::bp_be_issue_hazard_s)

package bp_be_pkg;

    typedef enum logic [1:0] {
        e_bp_default_cfg = 2'd0,
        e_bp_sv32_cfg    = 2'd1
    } bp_params_e;

    localparam int reg_addr_width_gp = 5;
    localparam int num_int_regs_gp   = 32;
    localparam int instr_width_gp    = 32;

    function automatic int bp_vaddr_width_f(input bp_params_e cfg);
        return (cfg == e_bp_sv32_cfg) ? 32 : 39;
    endfunction

    function automatic int bp_dword_width_f(input bp_params_e cfg);
        return (cfg == e_bp_sv32_cfg) ? 32 : 64;
    endfunction

    // Dispatch packet layout, MSB first: {v, pc, instr, imm}
    function automatic int bp_dispatch_pkt_width_f(input bp_params_e cfg);
        return 1 + bp_vaddr_width_f(cfg) + instr_width_gp + bp_dword_width_f(cfg);
    endfunction

    typedef struct packed {
        logic [reg_addr_width_gp-1:0] rs1_addr;
        logic                         rs1_r_v;
        logic [reg_addr_width_gp-1:0] rs2_addr;
        logic                         rs2_r_v;
        logic [reg_addr_width_gp-1:0] rd_addr;
        logic                         rd_w_v;
    } bp_be_issue_hazard_s;

endpackage

// File: rtl/bp_be_int_scoreboard.sv
// Integer register scoreboard: one pending bit per architectural register, set on issue,
// cleared on writeback, with a two-source hazard check that sees this cycle's clear.
module bp_be_int_scoreboard
    import bp_be_pkg::*;
(
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic                         set_v_i,
    input  logic [reg_addr_width_gp-1:0] set_addr_i,
    input  logic                         clr_v_i,
    input  logic [reg_addr_width_gp-1:0] clr_addr_i,
    input  logic [reg_addr_width_gp-1:0] rs1_addr_i,
    input  logic                         rs1_r_v_i,
    input  logic [reg_addr_width_gp-1:0] rs2_addr_i,
    input  logic                         rs2_r_v_i,
    output logic                         hazard_o
);

    logic [num_int_regs_gp-1:0] sb_r;
    logic [num_int_regs_gp-1:0] sb_clr;
    logic [num_int_regs_gp-1:0] sb_n;
    logic [num_int_regs_gp-1:0] set_mask;
    logic [num_int_regs_gp-1:0] clr_mask;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        set_mask = '0;
        clr_mask = '0;
        if (set_v_i) set_mask[set_addr_i] = 1'b1;
        if (clr_v_i) clr_mask[clr_addr_i] = 1'b1;

        // Hazard check uses the post-clear view so a same-cycle writeback unblocks issue
        sb_clr   = sb_r & ~clr_mask;
        // Set is applied after clear so a same-cycle issue to the same rd keeps the bit; x0 never pends
        sb_n     = (sb_clr | set_mask) & ~num_int_regs_gp'(1);
        hazard_o = (rs1_r_v_i & sb_clr[rs1_addr_i]) | (rs2_r_v_i & sb_clr[rs2_addr_i]);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) sb_r <= '0;
        else            sb_r <= sb_n;
    end

endmodule

// File: rtl/bp_be_int_issue_queue.sv
// In-order integer issue queue: FIFO of dispatch packets whose head issues to the integer
// pipe once its source registers are free in the scoreboard.
module bp_be_int_issue_queue
    import bp_be_pkg::*;
#(
    parameter bp_params_e bp_params_p = e_bp_default_cfg,
    parameter int         queue_els_p = 4,
    localparam int        dispatch_pkt_width_lp = bp_dispatch_pkt_width_f(bp_params_p)
)
(
    input  logic                                 clk_i,
    input  logic                                 reset_n_i,
    input  logic [dispatch_pkt_width_lp-1:0]     issue_pkt_i,
    input  logic [`BP_BE_ISSUE_HAZARD_WIDTH-1:0] issue_hazard_i,
    input  logic                                 issue_v_i,
    output logic                                 issue_ready_o,
    output logic [dispatch_pkt_width_lp-1:0]     reservation_o,
    input  logic                                 wb_v_i,
    input  logic [reg_addr_width_gp-1:0]         wb_rd_addr_i,
    input  logic                                 flush_i
);

    localparam int ptr_width_lp     = $clog2(queue_els_p);
    localparam int cnt_width_lp     = ptr_width_lp + 1;
    localparam int payload_width_lp = dispatch_pkt_width_lp - 1;
    localparam logic [cnt_width_lp-1:0] queue_els_lp = cnt_width_lp'(queue_els_p);

    typedef struct packed {
        logic [payload_width_lp-1:0] payload;
        bp_be_issue_hazard_s         hazard;
    } entry_s;

    entry_s                  mem_r [queue_els_p];
    entry_s                  head;
    entry_s                  enq_entry;
    logic [ptr_width_lp-1:0] rptr_r;
    logic [ptr_width_lp-1:0] wptr_r;
    logic [cnt_width_lp-1:0] count_r;
    logic                    empty;
    logic                    enq;
    logic                    issue;
    logic                    hazard;
    logic                    set_v;
    logic                    unused_pkt_v;

    // The incoming valid bit is replaced by the issue strobe on the way out
    assign unused_pkt_v = issue_pkt_i[dispatch_pkt_width_lp-1];

    always_comb begin
        enq_entry.payload = issue_pkt_i[payload_width_lp-1:0];
        enq_entry.hazard  = bp_be_issue_hazard_s'(issue_hazard_i);
    end

    assign head          = mem_r[rptr_r];
    assign empty         = (count_r == '0);
    // Ready ignores a same-cycle pop, so a full queue never has a comb path from issue to ready
    assign issue_ready_o = (count_r < queue_els_lp) & ~flush_i;
    assign enq           = issue_v_i & issue_ready_o;
    assign issue         = ~empty & ~flush_i & ~hazard;
    assign set_v         = issue & head.hazard.rd_w_v;
    assign reservation_o = {issue, head.payload};

    bp_be_int_scoreboard u_scoreboard (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .set_v_i    (set_v),
        .set_addr_i (head.hazard.rd_addr),
        .clr_v_i    (wb_v_i),
        .clr_addr_i (wb_rd_addr_i),
        .rs1_addr_i (head.hazard.rs1_addr),
        .rs1_r_v_i  (head.hazard.rs1_r_v),
        .rs2_addr_i (head.hazard.rs2_addr),
        .rs2_r_v_i  (head.hazard.rs2_r_v),
        .hazard_o   (hazard)
    );

    // NOTE: entry storage is not reset; count and pointers alone decide which entries are live.
    always_ff @(posedge clk_i) begin
        if (enq) mem_r[wptr_r] <= enq_entry;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rptr_r  <= '0;
            wptr_r  <= '0;
            count_r <= '0;
        end else if (flush_i) begin
            rptr_r  <= '0;
            wptr_r  <= '0;
            count_r <= '0;
        end else begin
            if (enq)   wptr_r <= wptr_r + ptr_width_lp'(1);
            if (issue) rptr_r <= rptr_r + ptr_width_lp'(1);
            count_r <= count_r + cnt_width_lp'(enq) - cnt_width_lp'(issue);
        end
    end

endmodule

// File: tb/tb_bp_be_int_issue_queue.sv
// Self-checking bench for bp_be_int_issue_queue: queue/pending-set model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_bp_be_int_issue_queue;
    import bp_be_pkg::*;

    localparam bp_params_e CFG   = e_bp_default_cfg;
    localparam int         DEPTH = 4;
    localparam int         VW    = bp_vaddr_width_f(CFG);
    localparam int         DWW   = bp_dword_width_f(CFG);
    localparam int         PW    = bp_dispatch_pkt_width_f(CFG);

    logic                clk;
    logic                rst_n;
    logic [PW-1:0]       issue_pkt;
    bp_be_issue_hazard_s issue_hazard;
    logic                issue_v;
    logic                issue_ready;
    logic [PW-1:0]       reservation;
    logic                wb_v;
    logic [4:0]          wb_rd;
    logic                flush;

    int checks = 0;
    int errors = 0;

    bp_be_int_issue_queue #(.bp_params_p(CFG), .queue_els_p(DEPTH)) dut (
        .clk_i          (clk),
        .reset_n_i      (rst_n),
        .issue_pkt_i    (issue_pkt),
        .issue_hazard_i (issue_hazard),
        .issue_v_i      (issue_v),
        .issue_ready_o  (issue_ready),
        .reservation_o  (reservation),
        .wb_v_i         (wb_v),
        .wb_rd_addr_i   (wb_rd),
        .flush_i        (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [PW-1:0] mk_pkt(input int tag);
        logic [VW-1:0]  pc;
        logic [31:0]    instr;
        logic [DWW-1:0] imm;
        pc    = VW'(32'h1000 + tag * 4);
        instr = 32'(tag);
        imm   = DWW'(tag) << 8;
        return {1'b1, pc, instr, imm};
    endfunction

    function automatic bp_be_issue_hazard_s mk_haz(input int rs1, input bit rs1v, input int rs2,
                                                   input bit rs2v, input int rd, input bit rdv);
        bp_be_issue_hazard_s h;
        h.rs1_addr = 5'(rs1); h.rs1_r_v = rs1v;
        h.rs2_addr = 5'(rs2); h.rs2_r_v = rs2v;
        h.rd_addr  = 5'(rd);  h.rd_w_v  = rdv;
        return h;
    endfunction

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [PW-1:0]       pkt;
        bp_be_issue_hazard_s haz;
    } m_entry_t;

    m_entry_t    mq[$];
    bit   [31:0] mpend;
    bit   [31:0] m_pend_c;
    bit          m_ready;
    bit          m_issue;
    m_entry_t    m_head;
    m_entry_t    m_new;

    // Inputs change just after a rising edge, so at the falling edge they are exactly what
    // the next rising edge will sample; the model advances here to the post-edge state.
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            mpend = '0;
        end else begin
            m_pend_c = mpend;
            if (wb_v) m_pend_c[wb_rd] = 1'b0;
            m_ready = (mq.size() < DEPTH) && !flush;
            m_issue = 1'b0;
            if (mq.size() > 0 && !flush) begin
                m_head  = mq[0];
                m_issue = !((m_head.haz.rs1_r_v && m_pend_c[m_head.haz.rs1_addr]) ||
                            (m_head.haz.rs2_r_v && m_pend_c[m_head.haz.rs2_addr]));
            end
            check("model_ready", issue_ready, m_ready);
            check("model_issue_v", reservation[PW-1], m_issue);
            if (m_issue && reservation[PW-1])
                check("model_payload", reservation[PW-2:0], m_head.pkt[PW-2:0]);
            check("model_scoreboard", dut.u_scoreboard.sb_r, mpend);
            check("model_count", dut.count_r, mq.size());

            if (flush) begin
                mq.delete();
            end else if (m_issue) begin
                if (m_head.haz.rd_w_v && m_head.haz.rd_addr != 5'd0) m_pend_c[m_head.haz.rd_addr] = 1'b1;
                void'(mq.pop_front());
            end
            if (issue_v && m_ready) begin
                m_new.pkt = issue_pkt;
                m_new.haz = issue_hazard;
                mq.push_back(m_new);
            end
            mpend = m_pend_c;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic enq(input int tag, input bp_be_issue_hazard_s h);
        issue_v      = 1'b1;
        issue_pkt    = mk_pkt(tag);
        issue_hazard = h;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; issue_v = 1'b0; issue_pkt = '0; issue_hazard = '0;
        wb_v = 1'b0; wb_rd = '0; flush = 1'b0;

        #3;
        check("reset_ready", issue_ready, 1'b1);
        check("reset_issue_v", reservation[PW-1], 1'b0);
        check("reset_count", dut.count_r, 0);

        // ADD x5 enqueued on the first edge after reset release, issues next cycle
        tick();
        rst_n = 1'b1;
        enq(1, mk_haz(1, 0, 2, 0, 5, 1));
        tick();
        issue_v = 1'b0;
        check("add_issue_v", reservation[PW-1], 1'b1);
        check("add_instr", reservation[DWW +: 32], 32'd1);
        tick();
        check("add_empty_after", dut.count_r, 0);
        check("add_sb5_set", dut.u_scoreboard.sb_r[5], 1'b1);

        // Read of x5 stalls until the writeback, then issues in the writeback cycle
        enq(2, mk_haz(5, 1, 0, 0, 6, 1));
        tick();
        issue_v = 1'b0;
        check("raw_stall0", reservation[PW-1], 1'b0);
        tick();
        check("raw_stall1", reservation[PW-1], 1'b0);
        wb_v = 1'b1; wb_rd = 5'd5;
        #1;
        check("raw_bypass_issue", reservation[PW-1], 1'b1);
        tick();
        wb_v = 1'b0;
        check("raw_sb5_cleared", dut.u_scoreboard.sb_r[5], 1'b0);
        check("raw_sb6_set", dut.u_scoreboard.sb_r[6], 1'b1);

        // Fill behind a head blocked on x6; a fifth packet is refused while full
        for (int i = 0; i < DEPTH; i++) begin
            enq(10 + i, mk_haz(6, 1, 0, 0, (i == 0) ? 0 : 16 + i, 1));
            tick();
        end
        enq(14, mk_haz(0, 0, 0, 0, 0, 0));
        check("full_ready", issue_ready, 1'b0);
        check("full_count", dut.count_r, 4);
        tick();
        issue_v = 1'b0;
        wb_v = 1'b1; wb_rd = 5'd6;
        #1;
        check("full_issue_refuse_ready", issue_ready, 1'b0);
        check("drain_instr0", reservation[DWW +: 32], 32'd10);
        tick();
        wb_v = 1'b0;
        enq(20, mk_haz(0, 0, 0, 0, 0, 0));
        for (int i = 1; i < DEPTH; i++) begin
            check("drain_v", reservation[PW-1], 1'b1);
            check("drain_instr", reservation[DWW +: 32], 32'(10 + i));
            tick();
            issue_v = 1'b0;
        end
        check("drain_tail_instr", reservation[DWW +: 32], 32'd20);
        tick();
        check("drain_empty", dut.count_r, 0);
        check("x0_never_set", dut.u_scoreboard.sb_r[0], 1'b0);

        // Issue writing x7 while a writeback to x7 arrives: set wins
        enq(30, mk_haz(0, 0, 0, 0, 7, 1));
        tick();
        issue_v = 1'b0;
        wb_v = 1'b1; wb_rd = 5'd7;
        tick();
        wb_v = 1'b0;
        check("set_wins_sb7", dut.u_scoreboard.sb_r[7], 1'b1);

        // Flush with three queued entries and x9 pending
        enq(40, mk_haz(0, 0, 0, 0, 9, 1));
        tick();
        enq(41, mk_haz(7, 1, 0, 0, 0, 0));
        tick();
        enq(42, mk_haz(9, 1, 0, 0, 0, 0));
        tick();
        enq(43, mk_haz(0, 0, 9, 1, 0, 0));
        tick();
        issue_v = 1'b0;
        check("flush_pre_count", dut.count_r, 3);
        flush = 1'b1; wb_v = 1'b1; wb_rd = 5'd7;
        enq(44, mk_haz(0, 0, 0, 0, 0, 0));
        #1;
        check("flush_no_issue", reservation[PW-1], 1'b0);
        check("flush_not_ready", issue_ready, 1'b0);
        tick();
        flush = 1'b0; wb_v = 1'b0; issue_v = 1'b0;
        check("flush_count0", dut.count_r, 0);
        check("flush_sb9_kept", dut.u_scoreboard.sb_r[9], 1'b1);

        // Asynchronous reset mid-stream
        enq(50, mk_haz(0, 0, 0, 0, 12, 1));
        tick();
        issue_v = 1'b0;
        check("pre_reset_issue_v", reservation[PW-1], 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset_issue_v", reservation[PW-1], 1'b0);
        check("async_reset_ready", issue_ready, 1'b1);
        check("async_reset_count", dut.count_r, 0);
        tick();
        tick();
        rst_n = 1'b1;
        check("post_reset_sb", dut.u_scoreboard.sb_r, 32'd0);
        check("post_reset_ready", issue_ready, 1'b1);
        enq(51, mk_haz(9, 1, 0, 0, 3, 1));
        tick();
        issue_v = 1'b0;
        check("post_reset_issue", reservation[PW-1], 1'b1);
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bp_be_int_issue_queue.md
BP_BE_INT_ISSUE_QUEUE -- requirements
Module: bp_be_int_issue_queue

Interface
REQ-001 The block SHALL take parameter bp_params_p, default e_bp_default_cfg, selecting processor configuration (vaddr_width_p, dword_width_p).
REQ-002 The block SHALL take parameter queue_els_p, default 4, giving queue depth, which is a power of two and at least 2.
REQ-003 clk_i  input  1  sole clock, all state on rising edge.
REQ-004 reset_n_i  input  1  asynchronous, active-low reset.
REQ-005 issue_pkt_i  input  dispatch_pkt_width_lp  decoded integer dispatch packet from the decode stage.
REQ-006 issue_hazard_i  input  bp_be_issue_hazard_s width  per-packet rs1/rs2 addresses with read-valids, and rd address with write-valid.
REQ-007 issue_v_i  input  1  issue_pkt_i/issue_hazard_i valid.
REQ-008 issue_ready_o  output  1  queue can accept; enqueue occurs when issue_v_i and issue_ready_o are both 1.
REQ-009 reservation_o  output  dispatch_pkt_width_lp  packet presented to the integer pipe; its .v field is the issue strobe.
REQ-010 wb_v_i  input  1  an integer result is written back this cycle.
REQ-011 wb_rd_addr_i  input  5  destination register of that writeback.
REQ-012 flush_i  input  1  discard all queued, not-yet-issued packets.

Function
REQ-013 The queue SHALL be an in-order FIFO of queue_els_p entries, each holding packet plus hazard info, with read and write pointers wrapping modulo queue_els_p.
REQ-014 issue_ready_o SHALL equal (count < queue_els_p) & ~flush_i; a full queue SHALL refuse enqueue even if the head issues that cycle.
REQ-015 A 32-bit scoreboard SHALL mark integer registers with an issued, not-yet-written-back result; bit 0 (x0) SHALL never be set.
REQ-016 The head SHALL issue when the queue is non-empty, flush_i=0, and no read-valid source address hits a scoreboard bit, after this cycle's wb clear is applied.
REQ-017 A writeback clear SHALL be visible combinationally to the same-cycle hazard check (wb-to-issue bypass).
REQ-018 On issue, reservation_o SHALL carry the head entry with .v=1 for exactly one cycle, the head SHALL pop, and the scoreboard bit for rd SHALL be set if write-valid and rd≠0.
REQ-019 When not issuing, reservation_o SHALL carry the head contents (don't-care) with .v forced to 0.
REQ-020 If an issue sets and a writeback clears the same rd in one cycle, set SHALL win.
REQ-021 Minimum enqueue-to-issue latency SHALL be 1 cycle, with no combinational path from issue_v_i to reservation_o.
REQ-022 Simultaneous enqueue and issue on a non-full queue SHALL leave count unchanged.
REQ-023 flush_i SHALL empty the queue in one cycle, suppress issue that cycle, and leave the scoreboard unchanged, since in-flight ops still write back.
REQ-024 A writeback to an unset bit SHALL have no effect.

Reset
REQ-025 While reset_n_i=0, count, pointers and scoreboard SHALL be 0, reservation_o.v SHALL be 0, and issue_ready_o SHALL be 1.
REQ-026 Reset assertion mid-operation SHALL discard all entries and pending bits immediately, asynchronously.
REQ-027 After reset deassertion, the first enqueue SHALL be accepted on the first rising edge.

Structure
REQ-028 Typedef bp_be_issue_hazard_s (rs1_addr, rs1_r_v, rs2_addr, rs2_r_v, rd_addr, rd_w_v) and its width macro SHALL live in bp_be_pkg.
REQ-029 The scoreboard SHALL be a sub-module bp_be_int_scoreboard with set, clear and a two-port hazard check.
REQ-030 The FIFO storage SHALL stay inline in bp_be_int_issue_queue.

Verification
REQ-031 Enqueue an ADD x5 with no hazards into an empty queue -> reservation_o.v=1 on the next cycle, then the queue is empty and scoreboard bit 5 is set.
REQ-032 Issue a write to x5, then enqueue a read of x5 -> it stalls with reservation_o.v=0 until wb_v_i=1 with wb_rd_addr_i=5, then issues in that same cycle.
REQ-033 Enqueue 4 packets with the head blocked -> issue_ready_o=0 while full; after the wb clear, the 4 packets issue on 4 consecutive cycles in order and pointers wrap.
REQ-034 In one cycle, issue a write to x7 while wb clears x7 -> bit 7 remains set.
REQ-035 Assert flush_i with 3 entries queued and x9 pending -> no issue that cycle, count=0 next cycle, bit 9 still set.
REQ-036 Assert reset_n_i=0 asynchronously mid-stream -> reservation_o.v drops without a clock edge, and after release issue_ready_o=1 and the scoreboard reads 0.
